seq_det_stream_ctrl: RTL and testbench
======================================

// Module: seq_det_stream_ctrl
// PURPOSE
//  Streaming controller for the serial "111" Mealy detector (din/y, async-high reset).
//  Accepts parallel words over valid/ready and serialises them into det_din, one bit per clk.
//  Counts detector hits, raises a sticky threshold interrupt and owns the detector's reset.
//  Back-to-back words stream without gaps, so patterns spanning word boundaries are detected.
// PARAMETERS
//  DATA_W  8  width of in_data; bits shifted per word (>=2)
//  CNT_W   8  width of hit_count and thresh
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       word available on in_data
//  in_ready   out  1       controller can take a word this cycle
//  in_data    in   DATA_W  word to serialise
//  cnt_clr    in   1       sync clear of hit_count/irq; also resets detector
//  thresh     in   CNT_W   irq threshold; 0 = irq disabled
//  det_din    out  1       serial bit to detector din
//  det_reset  out  1       detector reset
//  det_y      in   1       detector output y (combinational, same cycle as det_din)
//  hit_count  out  CNT_W   saturating hit counter
//  hit_pulse  out  1       registered det_y: 1 cycle after each hit
//  word_done  out  1       1-cycle pulse, cycle after a word's last bit
//  busy       out  1       high in SHIFT
//  irq        out  1       sticky: hit_count reached thresh
// BEHAVIOUR
//  - Reset: state=IDLE; hit_count=0, hit_pulse=0, word_done=0, irq=0, busy=0, det_din=0.
//    in_ready forced 0 while reset=1.
//  - det_reset = reset | cnt_clr (combinational).
//  - FSM: IDLE, SHIFT. bit_cnt counts DATA_W-1 down to 0.
//  - IDLE: in_ready=1, det_din=0. Accept (in_valid & in_ready):
//    load shreg, bit_cnt=DATA_W-1, go SHIFT.
//  - SHIFT: det_din=shreg[DATA_W-1] (MSB first); shreg shifts left, bit_cnt-- each clk.
//    in_ready=1 only when bit_cnt==0.
//  - Last bit (bit_cnt==0): accept -> reload, stay SHIFT, next bit follows with no gap.
//    No accept -> IDLE. word_done=1 on the following cycle in both cases.
//  - Latency: word accepted at edge T; its bit k (0=MSB) is on det_din in cycle T+1+k.
//  - Gaps: any IDLE cycle drives det_din=0, which returns the detector to s0.
//    Patterns do not span a gap.
//  - Hit: det_y & (state==SHIFT) in a cycle.
//    hit_count += 1 at next edge, saturating at 2^CNT_W-1. hit_pulse=1 next cycle.
//    det_y is ignored in IDLE.
//  - irq sets at the edge where hit_count becomes == thresh (thresh!=0). Holds until cnt_clr/reset.
//  - cnt_clr: hit_count=0, irq=0 next edge; wins over a simultaneous hit.
//    FSM/shreg unaffected. The detector is reset, so a pattern in progress is lost.
//  - reset mid-word: word discarded, no word_done, detector reset.
// CONFIGURATION
//  SEQ_DET_STREAM_LSB_FIRST_EN
//    defined:   det_din=shreg[0], shreg shifts right; bit k on det_din = in_data[k].
//    undefined: MSB first as above. Timing, handshake and counters are identical.
// TESTING  (DATA_W=8, CNT_W=8, real detector attached, MSB first unless noted)
//  1 word 0xE0, thresh=0 -> det_y in cycle T+3 only.
//    hit_count=1, word_done at T+9, irq stays 0.
//  2 word 0xFF -> 6 hits (bits 2..7); hit_count=6.
//    thresh=6 -> irq rises the edge after bit 7.
//  3 0x03 then 0x80 back-to-back (in_valid held) -> in_ready=1 only on last-bit cycles.
//    1 hit at first bit of 2nd word. Same words with 1 idle cycle between -> 0 hits.
//  4 CNT_W=4, three words 0xFF back-to-back (6+8+8=22 hits) -> hit_count saturates at 15, no wrap.
//  5 cnt_clr asserted in the same cycle as a hit during 0xFF -> hit_count=0, irq=0, det_reset=1 that cycle.
//    Shifting continues; the detector restarts counting from s0.
//  6 reset at bit 4 of 0xFF -> outputs 0 next edge, no word_done.
//    Next word 0xE0 gives hit_count=1. LSB_FIRST_EN: word 0x07 -> 1 hit at bit 2.

Source files
------------

// File: rtl/seq_det_stream_ctrl_if.sv
// Parallel word stream into the serial detector controller: valid/ready/data.
interface seq_det_stream_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_det_stream_ctrl.sv
// Serialises stream words into a "111" Mealy detector, counts its hits and raises a sticky irq.
// Optional: define SEQ_DET_STREAM_LSB_FIRST_EN to shift words out LSB first.
module seq_det_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_det_stream_ctrl_if.slave  in_if,
    input  logic                  cnt_clr,
    input  logic [CNT_W-1:0]      thresh,
    output logic                  det_din,
    output logic                  det_reset,
    input  logic                  det_y,
    output logic [CNT_W-1:0]      hit_count,
    output logic                  hit_pulse,
    output logic                  word_done,
    output logic                  busy,
    output logic                  irq
);
    localparam int               BC_W    = $clog2(DATA_W);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  hit_count_q, hit_count_d;
    logic              hit_pulse_q, hit_pulse_d;
    logic              word_done_q, word_done_d;
    logic              irq_q, irq_d;
    logic              in_ready_c;
    logic              det_din_c;
    logic              hit_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            hit_count_q <= '0;
            hit_pulse_q <= 1'b0;
            word_done_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            hit_count_q <= hit_count_d;
            hit_pulse_q <= hit_pulse_d;
            word_done_q <= word_done_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        hit_count_d = hit_count_q;
        irq_d       = irq_q;
        word_done_d = 1'b0;
        in_ready_c  = 1'b0;
        det_din_c   = 1'b0;
        // The detector output only means something while real bits are on det_din.
        hit_c       = det_y && (state_q == SHIFT);
        hit_pulse_d = hit_c;

        case (state_q)
            IDLE: begin
                in_ready_c = !reset;
                if (in_if.in_valid && in_ready_c) begin
                    shreg_d   = in_if.in_data;
                    bit_cnt_d = BC_LAST;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
`ifdef SEQ_DET_STREAM_LSB_FIRST_EN
                det_din_c = shreg_q[0];
                shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
`else
                det_din_c = shreg_q[DATA_W-1];
                shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
`endif
                bit_cnt_d  = bit_cnt_q - 1'b1;
                in_ready_c = !reset && (bit_cnt_q == '0);
                if (bit_cnt_q == '0) begin
                    word_done_d = 1'b1;
                    // Reloading on the last bit keeps the serial stream gap-free.
                    if (in_if.in_valid && in_ready_c) begin
                        shreg_d   = in_if.in_data;
                        bit_cnt_d = BC_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cnt_clr) begin
            hit_count_d = '0;
            irq_d       = 1'b0;
        end else if (hit_c && (hit_count_q != CNT_MAX)) begin
            hit_count_d = hit_count_q + 1'b1;
            if ((thresh != '0) && (hit_count_d == thresh)) begin
                irq_d = 1'b1;
            end
        end
    end

    assign in_if.in_ready = in_ready_c;
    assign det_din        = det_din_c;
    assign det_reset      = reset | cnt_clr;
    assign hit_count      = hit_count_q;
    assign hit_pulse      = hit_pulse_q;
    assign word_done      = word_done_q;
    assign busy           = (state_q == SHIFT);
    assign irq            = irq_q;
endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Bench for seq_det_stream_ctrl with a behavioural "111" detector attached and a
// run-length hit model of the serial stream.
module tb_seq_det_stream_ctrl;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cnt_clr;
    logic [CW-1:0] thresh;
    logic          det_din, det_reset, det_y;
    logic [CW-1:0] hit_count;
    logic          hit_pulse, word_done, busy, irq;

    seq_det_stream_ctrl_if #(.DATA_W(DW)) s_if ();

    seq_det_stream_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_if     (s_if),
        .cnt_clr   (cnt_clr),
        .thresh    (thresh),
        .det_din   (det_din),
        .det_reset (det_reset),
        .det_y     (det_y),
        .hit_count (hit_count),
        .hit_pulse (hit_pulse),
        .word_done (word_done),
        .busy      (busy),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Overlapping "111" Mealy detector, asynchronous active-high reset.
    logic [1:0] det_st;
    always @(posedge clk or posedge det_reset) begin
        if (det_reset)    det_st <= 2'd0;
        else if (!det_din) det_st <= 2'd0;
        else if (det_st != 2'd2) det_st <= det_st + 2'd1;
    end
    assign det_y = det_din & (det_st == 2'd2);

    int wd_total = 0;
    int hp_total = 0;
    always @(negedge clk) begin
        if (word_done === 1'b1) wd_total++;
        if (hit_pulse === 1'b1) hp_total++;
    end

    int tests = 0;
    int fails = 0;
    int ref_run, ref_hits, ref_words;
    logic ref_irq;
    int wd_base, hp_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [7:0] w, input int k);
`ifdef SEQ_DET_STREAM_LSB_FIRST_EN
        return w[k];
`else
        return w[7-k];
`endif
    endfunction

    // Count every position where the last three streamed bits are all ones.
    task automatic model_word(input logic [7:0] w, input bit contiguous);
        if (!contiguous) ref_run = 0;
        for (int k = 0; k < 8; k++) begin
            ref_run = bit_at(w, k) ? ref_run + 1 : 0;
            if (ref_run >= 3) begin
                ref_hits++;
                if (thresh != 0 && ref_hits == int'(thresh)) ref_irq = 1'b1;
            end
        end
        ref_words++;
    endtask

    task automatic rebase();
        ref_run = 0; ref_hits = 0; ref_words = 0; ref_irq = 1'b0;
        wd_base = wd_total; hp_base = hp_total;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        for (n = 0; n < 40; n++) begin
            if (busy === 1'b0) break;
            tick();
        end
        check({tag, "_idle_timeout"}, 32'(n < 40), 32'd1);
    endtask

    task automatic send(input logic [7:0] w, input bit b2b);
        int n;
        if (!b2b) begin
            s_if.in_valid = 1'b0;
            wait_idle("send");
        end
        s_if.in_valid = 1'b1;
        s_if.in_data  = w;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (s_if.in_ready === 1'b1) break;
        end
        check("accept_timeout", 32'(n < 40), 32'd1);
        @(posedge clk); #1;
        model_word(w, b2b);
    endtask

    task automatic drain(input string tag);
        s_if.in_valid = 1'b0;
        wait_idle(tag);
        tick();
    endtask

    task automatic check_counts(input string tag);
        int sat;
        sat = (ref_hits > 255) ? 255 : ref_hits;
        check({tag, "_hit_count"}, 32'(hit_count), 32'(sat));
        check({tag, "_irq"}, 32'(irq), 32'(ref_irq));
        check({tag, "_word_done_cnt"}, 32'(wd_total - wd_base), 32'(ref_words));
        check({tag, "_hit_pulse_cnt"}, 32'(hp_total - hp_base), 32'(ref_hits));
    endtask

    task automatic do_clear();
        cnt_clr = 1'b1;
        #1 check("clr_det_reset", 32'(det_reset), 32'd1);
        tick();
        cnt_clr = 1'b0;
        rebase();
    endtask

    // Word sent from IDLE with its bit-by-bit serial output checked cycle by cycle.
    task automatic send_traced(input string tag, input logic [7:0] w);
        int run;
        send(w, 1'b0);
        s_if.in_valid = 1'b0;
        run = 0;
        for (int k = 0; k < 8; k++) begin
            run = bit_at(w, k) ? run + 1 : 0;
            check({tag, "_det_din"}, 32'(det_din), 32'(bit_at(w, k)));
            check({tag, "_det_y"}, 32'(det_y), 32'(run >= 3));
            check({tag, "_in_ready"}, 32'(s_if.in_ready), 32'(k == 7));
            check({tag, "_word_done_early"}, 32'(word_done), 32'(0));
            tick();
        end
        check({tag, "_word_done"}, 32'(word_done), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cnt_clr = 1'b0; thresh = '0;
        s_if.in_valid = 1'b0; s_if.in_data = '0;
        #1;
        check("rst_in_ready", 32'(s_if.in_ready), 32'd0);
        check("rst_det_reset", 32'(det_reset), 32'd1);
        tick(); tick();
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_flags", {28'd0, busy, irq, word_done, hit_pulse}, 32'd0);
        check("rst_det_din", 32'(det_din), 32'd0);
        reset = 1'b0;
        #1 check("rst_release_ready", 32'(s_if.in_ready), 32'd1);
        rebase();

        // Single word with a pattern at the front; irq disabled.
        send_traced("t1", 8'hE0);
        drain("t1");
        check_counts("t1");
        check("t1_hits_const", 32'(hit_count), 32'd1);

        // Run of ones with threshold at the hit total.
        do_clear();
        thresh = 8'd6;
        send(8'hFF, 1'b0);
        drain("t2");
        check_counts("t2");
        check("t2_irq_const", 32'(irq), 32'd1);

        // Cross-word pattern only when back-to-back.
        do_clear();
        thresh = '0;
        send_traced("t3r", 8'h03);
        do_clear();
        send(8'h03, 1'b0);
        send(8'h80, 1'b1);
        drain("t3a");
        check_counts("t3a");
        check("t3_b2b_hits", 32'(hit_count), 32'd1);
        do_clear();
        send(8'h03, 1'b0);
        send(8'h80, 1'b0);
        drain("t3b");
        check_counts("t3b");
        check("t3_gap_hits", 32'(hit_count), 32'd0);

        // Clear colliding with a hit in the middle of a word.
        do_clear();
        thresh = 8'd1;
        send(8'hFF, 1'b0);
        s_if.in_valid = 1'b0;
        tick(); tick(); tick();
        check("t5_hit_before_clr", 32'(det_y), 32'd1);
        check("t5_irq_before_clr", 32'(irq), 32'd1);
        cnt_clr = 1'b1;
        #1 check("t5_det_reset", 32'(det_reset), 32'd1);
        tick();
        cnt_clr = 1'b0;
        check("t5_count_cleared", 32'(hit_count), 32'd0);
        check("t5_irq_cleared", 32'(irq), 32'd0);
        check("t5_still_busy", 32'(busy), 32'd1);
        drain("t5");
        check("t5_hits_after", 32'(hit_count), 32'd2);
        check("t5_irq_after", 32'(irq), 32'd1);

        // Reset in the middle of a word.
        thresh = '0;
        do_clear();
        send(8'hFF, 1'b0);
        s_if.in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("t6_in_ready_rst", 32'(s_if.in_ready), 32'd0);
        check("t6_det_reset", 32'(det_reset), 32'd1);
        tick();
        check("t6_hit_count", 32'(hit_count), 32'd0);
        check("t6_flags", {28'd0, busy, irq, word_done, hit_pulse}, 32'd0);
        check("t6_det_din", 32'(det_din), 32'd0);
        reset = 1'b0;
        rebase();
        tick();
        check("t6_no_word_done", 32'(word_done), 32'd0);
        send(8'hE0, 1'b0);
        drain("t6");
        check_counts("t6");

        // Random words, gaps and thresholds against the stream model.
        for (int r = 0; r < 8; r++) begin
            int nw;
            do_clear();
            thresh = 8'($urandom_range(1, 20));
            nw = $urandom_range(2, 5);
            for (int i = 0; i < nw; i++) begin
                send(8'($urandom | $urandom), (i > 0) && ($urandom_range(0, 1) == 1));
            end
            drain("rnd");
            check_counts("rnd");
        end

        // Saturation: 6 + 33*8 = 270 hits.
        do_clear();
        thresh = '0;
        for (int i = 0; i < 34; i++) send(8'hFF, i > 0);
        drain("sat");
        check_counts("sat");
        check("sat_const", 32'(hit_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
